// File: rtl/lzrw1_pkg.sv
// Shared types and constants for the LZRW1 input feeder.
package lzrw1_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic {
      STREAM    = 1'b0,
      WAIT_DONE = 1'b1
   } feeder_state_t;

   localparam int unsigned DEFAULT_BLOCK_BYTES = 4096;

endpackage

// File: rtl/lzrw1_input_feeder_sync_fifo.sv
// Single-clock FIFO with occupancy counter; read data is the head entry (show-ahead).
module sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   // Qualify requests against the current occupancy
   always_comb begin
      full    = (count_q == (AW+1)'(DEPTH));
      empty   = (count_q == '0);
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      rdata   = mem_q[rd_ptr_q];
   end

   // Pointers wrap naturally; occupancy is unchanged on simultaneous push and pop
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
         else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
      end
   end

   // Storage array, written on accepted pushes only
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/lzrw1_input_feeder.sv
// Buffers host bytes and feeds them to the LZRW1 core one block at a time.
module lzrw1_input_feeder
   import lzrw1_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned BLOCK_BYTES = DEFAULT_BLOCK_BYTES,
   parameter int unsigned CNT_W       = $clog2(BLOCK_BYTES + 1)
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        valid,
   output logic [7:0]  CurByte,
   output logic        block_last,
   input  logic        finished_cycle,
   output logic        busy,
   output logic [15:0] block_count
);

   logic [8:0]       fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;

   feeder_state_t    state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             last_d;
   logic             valid_q;
   byte_t            cur_q;
   logic             bl_q;
   logic [15:0]      bc_q;

   sync_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .wdata ({in_last, in_data}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Handshake, pop request and block-end decision for the head byte
   always_comb begin
      in_ready  = ~fifo_full;
      fifo_push = in_valid & ~fifo_full;
      fifo_pop  = (state_q == STREAM) & ~fifo_empty;
      last_d    = fifo_rdata[8] | (cnt_q == CNT_W'(BLOCK_BYTES - 1));
      cnt_d     = last_d ? '0 : cnt_q + CNT_W'(1);
   end

   // Feeder FSM with registered compressor-side outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= STREAM;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         cur_q   <= '0;
         bl_q    <= 1'b0;
         bc_q    <= '0;
      end else begin
         case (state_q)
            STREAM: begin
               if (fifo_pop) begin
                  valid_q <= 1'b1;
                  cur_q   <= fifo_rdata[7:0];
                  bl_q    <= last_d;
                  cnt_q   <= cnt_d;
                  if (last_d) state_q <= WAIT_DONE;
               end else begin
                  valid_q <= 1'b0;
                  bl_q    <= 1'b0;
               end
            end
            WAIT_DONE: begin
               valid_q <= 1'b0;
               bl_q    <= 1'b0;
               if (finished_cycle) begin
                  bc_q    <= bc_q + 16'(1);
                  state_q <= STREAM;
               end
            end
            default: state_q <= STREAM;
         endcase
      end
   end

   // Output drive
   always_comb begin
      valid       = valid_q;
      CurByte     = cur_q;
      block_last  = bl_q;
      block_count = bc_q;
      busy        = ~fifo_empty | (state_q == WAIT_DONE) | valid_q;
   end

endmodule
